// File: rtl/vtg_pix_streamer.sv
// Raster timing generator: turns a ready/valid pixel stream into a di/de/hs/vs
// video bus with programmable active size and blanking, latched per frame.
module vtg_pix_streamer #(
  parameter int DW = 24,
  parameter int XW = 12,
  parameter int YW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [XW-1:0] cfg_w,
  input  logic [YW-1:0] cfg_h,
  input  logic [7:0]    cfg_hb,
  input  logic [15:0]   cfg_vb,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] di_o,
  output logic          de_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          frame_done,
  output logic          cfg_err,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  state_t        state_reg, state_next;
  logic [XW-1:0] x_reg, x_next, w_reg, w_next;
  logic [YW-1:0] y_reg, y_next, h_reg, h_next;
  logic [7:0]    hb_reg, hb_next, hb_cnt_reg, hb_cnt_next;
  logic [15:0]   vb_reg, vb_next, vb_cnt_reg, vb_cnt_next;
  logic [DW-1:0] di_reg, di_next;
  logic          de_reg, de_next;
  logic          hs_reg, hs_next;
  logic          vs_reg, vs_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic [15:0]   fcnt_reg, fcnt_next;
  logic          start_chk;
  logic          pix_fire;
  logic          last_x;
  logic          last_y;

  assign s_ready  = (state_reg == ACTIVE);
  assign pix_fire = s_valid & s_ready;
  assign last_x   = (x_reg == (w_reg - XW'(1)));
  assign last_y   = (y_reg == (h_reg - YW'(1)));

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    w_next      = w_reg;
    h_next      = h_reg;
    hb_next     = hb_reg;
    vb_next     = vb_reg;
    hb_cnt_next = hb_cnt_reg;
    vb_cnt_next = vb_cnt_reg;
    di_next     = di_reg;
    de_next     = 1'b0;
    hs_next     = 1'b0;
    vs_next     = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    fcnt_next   = fcnt_reg;
    start_chk   = 1'b0;

    case (state_reg)
      IDLE: start_chk = en;

      ACTIVE: begin
        if (pix_fire) begin
          di_next = s_data;
          de_next = 1'b1;
          if (last_x) begin
            x_next = '0;
            if (hb_reg != 8'd0) begin
              state_next  = HBLANK;
              hb_cnt_next = hb_reg - 8'd1;
            end else if (!last_y) begin
              y_next = y_reg + YW'(1);
            end else begin
              state_next  = VBLANK;
              vb_cnt_next = vb_reg;
            end
          end else begin
            x_next = x_reg + XW'(1);
          end
        end
      end

      HBLANK: begin
        hs_next = 1'b1;
        if (hb_cnt_reg == 8'd0) begin
          if (!last_y) begin
            y_next     = y_reg + YW'(1);
            state_next = ACTIVE;
          end else begin
            state_next  = VBLANK;
            vb_cnt_next = vb_reg;
          end
        end else begin
          hb_cnt_next = hb_cnt_reg - 8'd1;
        end
      end

      VBLANK: begin
        // Counter reaching zero is the frame-completion cycle (no vs_o).
        if (vb_cnt_reg != 16'd0) begin
          vs_next     = 1'b1;
          vb_cnt_next = vb_cnt_reg - 16'd1;
        end else begin
          done_next  = 1'b1;
          fcnt_next  = fcnt_reg + 16'd1;
          state_next = IDLE;
          start_chk  = en;
        end
      end

      default: state_next = IDLE;
    endcase

    // Frame start: validate the live config and capture it into the shadows.
    if (start_chk) begin
      if (cfg_w == '0 || cfg_h == '0) begin
        err_next   = 1'b1;
        state_next = IDLE;
      end else begin
        w_next     = cfg_w;
        h_next     = cfg_h;
        hb_next    = cfg_hb;
        vb_next    = cfg_vb;
        x_next     = '0;
        y_next     = '0;
        state_next = ACTIVE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      w_reg      <= '0;
      h_reg      <= '0;
      hb_reg     <= '0;
      vb_reg     <= '0;
      hb_cnt_reg <= '0;
      vb_cnt_reg <= '0;
      di_reg     <= '0;
      de_reg     <= 1'b0;
      hs_reg     <= 1'b0;
      vs_reg     <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      fcnt_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      w_reg      <= w_next;
      h_reg      <= h_next;
      hb_reg     <= hb_next;
      vb_reg     <= vb_next;
      hb_cnt_reg <= hb_cnt_next;
      vb_cnt_reg <= vb_cnt_next;
      di_reg     <= di_next;
      de_reg     <= de_next;
      hs_reg     <= hs_next;
      vs_reg     <= vs_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      fcnt_reg   <= fcnt_next;
    end
  end

  assign di_o       = di_reg;
  assign de_o       = de_reg;
  assign hs_o       = hs_reg;
  assign vs_o       = vs_reg;
  assign frame_done = done_reg;
  assign cfg_err    = err_reg;
  assign frame_cnt  = fcnt_reg;

endmodule

// File: tb/tb_vtg_pix_streamer.sv
// Bench for vtg_pix_streamer: per-cycle expectations are built from a timeline
// model (pixel handshake times, blanking lengths) and compared every cycle.
module tb_vtg_pix_streamer;

  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] cfg_w = '0;
  logic [11:0] cfg_h = '0;
  logic [7:0]  cfg_hb = '0;
  logic [15:0] cfg_vb = '0;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] di_o;
  logic        de_o, hs_o, vs_o, frame_done, cfg_err;
  logic [15:0] frame_cnt;

  vtg_pix_streamer #(.DW(24), .XW(12), .YW(12)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_hb(cfg_hb), .cfg_vb(cfg_vb),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .di_o(di_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
    .frame_done(frame_done), .cfg_err(cfg_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // expected outputs and driven inputs, indexed by cycle within a scenario
  bit          e_rdy[MAXC], e_de[MAXC], e_hs[MAXC], e_vs[MAXC], e_fd[MAXC], e_err[MAXC];
  logic [23:0] e_di[MAXC];
  logic [15:0] e_fc[MAXC];
  bit          d_vld[MAXC], d_en[MAXC];
  logic [23:0] d_dat[MAXC];
  logic [11:0] d_w[MAXC], d_h[MAXC];
  logic [7:0]  d_hb[MAXC];
  logic [15:0] d_vb[MAXC];

  int          fr_w[4], fr_h[4], fr_hb[4], fr_vb[4];
  int          n_fr, dmode, n_inval, scen_len;
  bit          seq_data, bad_end;
  logic [15:0] fcnt_model = '0;
  int          first_de, done_c;
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_cfg(input int from, input int f);
    for (int i = from; i < MAXC; i++) begin
      d_w[i]  = 12'(fr_w[f]);
      d_h[i]  = 12'(fr_h[f]);
      d_hb[i] = 8'(fr_hb[f]);
      d_vb[i] = 16'(fr_vb[f]);
    end
  endtask

  // Timeline model: line = w handshakes (with chosen gaps), then hb hs cycles;
  // frame = h lines, then vb vs cycles, then a frame_done cycle.
  task automatic build();
    int r, e, b, done, hc, d, fstart, prev_start, drop, pix, fp, a;
    logic [15:0] cnt;
    for (int i = 0; i < MAXC; i++) begin
      e_rdy[i] = 0; e_de[i] = 0; e_hs[i] = 0; e_vs[i] = 0; e_fd[i] = 0; e_err[i] = 0;
      e_di[i]  = '0;
      d_vld[i] = 1'($urandom % 2);
      d_dat[i] = 24'($urandom);
      d_en[i]  = 0;
    end
    fill_cfg(0, 0);
    pix = 0; done = 0;
    if (n_inval > 0) begin
      for (int k = 0; k < n_inval; k++) begin
        a = 1 + 3 * k;
        d_en[a] = 1;
        if (k % 2 == 0) d_w[a] = '0; else d_h[a] = '0;
        e_err[a+1] = 1;
      end
      scen_len = 3 * n_inval + 4;
    end else begin
      d_en[0] = 1; r = 1; prev_start = 0;
      for (int f = 0; f < n_fr; f++) begin
        if (f > 0) fill_cfg(prev_start + 1, f);
        fstart = r; fp = 0; b = r;
        for (int l = 0; l < fr_h[f]; l++) begin
          for (int k = 0; k < fr_w[f]; k++) begin
            case (dmode)
              0:       d = 0;
              1:       d = (fp == 0) ? 0 : 1;
              default: d = int'($urandom % 3);
            endcase
            for (int i = r; i < r + d; i++) begin
              d_vld[i] = 0; e_rdy[i] = 1;
            end
            hc = r + d;
            d_vld[hc] = 1; e_rdy[hc] = 1;
            if (seq_data) d_dat[hc] = 24'(pix);
            e_de[hc+1] = 1; e_di[hc+1] = d_dat[hc];
            pix++; fp++;
            r = hc + 1;
          end
          e = r;
          for (int i = 1; i <= fr_hb[f]; i++) e_hs[e+i] = 1;
          b = e + fr_hb[f];
          if (l < fr_h[f] - 1) r = b;
        end
        for (int i = 1; i <= fr_vb[f]; i++) e_vs[b+i] = 1;
        done = b + fr_vb[f] + 1;
        e_fd[done] = 1;
        for (int i = fstart; i <= done - 2; i++) d_en[i] = 1'($urandom % 2);
        if (f < n_fr - 1) begin
          d_en[done-1] = 1;
        end else if (bad_end) begin
          d_en[done-1] = 1;
          for (int i = fstart + 1; i < MAXC; i++) d_w[i] = '0;
          e_err[done] = 1;
        end else begin
          drop = fstart + 1 + int'($urandom % 32'(done - 1 - fstart));
          for (int i = drop; i <= done - 1; i++) d_en[i] = 0;
        end
        prev_start = fstart;
        r = done;
      end
      scen_len = done + 4;
    end
    cnt = fcnt_model;
    for (int i = 0; i < scen_len; i++) begin
      if (e_fd[i]) cnt = cnt + 16'd1;
      e_fc[i] = cnt;
    end
    fcnt_model = cnt;
  endtask

  // Called at posedge+1; drives cycle c inputs and checks cycle c outputs.
  task automatic run_scen(input string name, input int ncyc);
    first_de = -1; done_c = -1;
    for (int c = 0; c < ncyc; c++) begin
      en = d_en[c]; s_valid = d_vld[c]; s_data = d_dat[c];
      cfg_w = d_w[c]; cfg_h = d_h[c]; cfg_hb = d_hb[c]; cfg_vb = d_vb[c];
      check_val($sformatf("%s.ctl@%0d", name, c),
                64'({s_ready, de_o, hs_o, vs_o, frame_done, cfg_err}),
                64'({e_rdy[c], e_de[c], e_hs[c], e_vs[c], e_fd[c], e_err[c]}));
      check_val($sformatf("%s.fcnt@%0d", name, c), 64'(frame_cnt), 64'(e_fc[c]));
      if (e_de[c]) check_val($sformatf("%s.di@%0d", name, c), 64'(di_o), 64'(e_di[c]));
      if (de_o && first_de < 0) first_de = c;
      if (frame_done && done_c < 0) done_c = c;
      if (e_fd[c]) $display("%s: frame done @cycle %0d frame_cnt=%0d", name, c, frame_cnt);
      if (e_err[c]) $display("%s: start rejected @cycle %0d cfg_err=%0d", name, c, cfg_err);
      @(posedge clk); #1;
    end
  endtask

  task automatic set_one(input int w, input int h, input int hb, input int vb);
    n_fr = 1; fr_w[0] = w; fr_h[0] = h; fr_hb[0] = hb; fr_vb[0] = vb;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_inval = 0; bad_end = 0; seq_data = 1; dmode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset", 64'({s_ready, de_o, hs_o, vs_o, frame_done, cfg_err, frame_cnt, di_o}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // continuous 4x2 frame, hb=3 vb=5
    set_one(4, 2, 3, 5); dmode = 0; seq_data = 1;
    build(); run_scen("cont4x2", scen_len);
    check_val("de_to_done", 64'(done_c - first_de), 64'd19);

    // alternating valid
    set_one(4, 2, 3, 5); dmode = 1;
    build(); run_scen("gap4x2", scen_len);

    // no blanking: 9 back-to-back pixels
    set_one(3, 3, 0, 0); dmode = 0;
    build(); run_scen("noblank", scen_len);
    check_val("nb_de_to_done", 64'(done_c - first_de), 64'd9);

    // rejected starts
    n_inval = 3;
    build(); run_scen("badcfg", scen_len);
    n_inval = 0;

    // width changes mid-frame, en dropped inside the final frame
    n_fr = 2; seq_data = 0; dmode = 2;
    fr_w[0] = 4; fr_h[0] = 2; fr_hb[0] = 3; fr_vb[0] = 5;
    fr_w[1] = 8; fr_h[1] = 2; fr_hb[1] = 3; fr_vb[1] = 5;
    build(); run_scen("wchange", scen_len);

    // restart with invalid config at frame completion
    bad_end = 1;
    build(); run_scen("badrestart", scen_len);
    bad_end = 0;

    // asynchronous reset mid-line
    set_one(4, 2, 3, 5); dmode = 0; seq_data = 1;
    build(); run_scen("prerst", 3);
    check_val("pre_rst_de", 64'(de_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_async", 64'({s_ready, de_o, hs_o, vs_o, frame_done, cfg_err, frame_cnt, di_o}), 64'd0);
    en = 0; s_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fcnt_model = '0;
    @(posedge clk); #1;
    build(); run_scen("postrst", scen_len);

    // randomized frames
    seq_data = 0; dmode = 2;
    for (int s = 0; s < 8; s++) begin
      n_fr = 1 + int'($urandom % 3);
      for (int f = 0; f < n_fr; f++) begin
        fr_w[f]  = 1 + int'($urandom % 8);
        fr_h[f]  = 1 + int'($urandom % 4);
        fr_hb[f] = ($urandom % 4 == 0) ? 0 : 1 + int'($urandom % 4);
        fr_vb[f] = ($urandom % 4 == 0) ? 0 : 1 + int'($urandom % 6);
      end
      bad_end = ($urandom % 4 == 0);
      build(); run_scen($sformatf("rnd%0d", s), scen_len);
    end
    bad_end = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
